// File: rtl/frame_pkg.sv
// Shared types and constants for the frame deframer: parser states, default
// start-of-frame marker and statistics counter width.
package frame_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CHK     = 2'd3
  } state_t;

  localparam logic [7:0] DEF_SOF_BYTE = 8'hA5;
  localparam int         CNT_W        = 16;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter
  import frame_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/frame_deframer.sv
// Pulls SOF/length/payload/checksum frames out of a show-ahead FIFO, streams the
// payload downstream and reports per-frame status plus running statistics.
module frame_deframer
  import frame_pkg::*;
#(
  parameter int                  DATA_WIDTH = 8,
  parameter logic [7:0]          SOF_BYTE   = DEF_SOF_BYTE,
  parameter int                  MAX_LEN    = 64
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  fifo_rempty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_ren,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  stat_valid,
  output logic                  stat_ok,
  output logic [CNT_W-1:0]      ok_cnt,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [CNT_W-1:0]      drop_cnt
);

  localparam logic [DATA_WIDTH-1:0] MAX_LEN_B = DATA_WIDTH'(MAX_LEN);
  localparam logic [DATA_WIDTH-1:0] ONE_B     = DATA_WIDTH'(1);

  state_t                  state;
  logic [DATA_WIDTH-1:0]   acc;
  logic [DATA_WIDTH-1:0]   remain;
  logic                    len_ok;
  logic                    sum_ok;
  logic                    ok_inc;
  logic                    err_inc;
  logic                    drop_inc;

  // Pop/valid are combinational so a byte can move every cycle; reset gates them at once.
  always_comb begin
    fifo_ren = 1'b0;
    m_valid  = 1'b0;
    if (!rrst) begin
      case (state)
        PAYLOAD: begin
          m_valid  = !fifo_rempty;
          fifo_ren = !fifo_rempty && m_ready;
        end
        default: fifo_ren = !fifo_rempty;
      endcase
    end
  end

  assign m_data = fifo_rdata;
  assign m_last = m_valid && (remain == ONE_B);
  assign len_ok = (fifo_rdata != '0) && (fifo_rdata <= MAX_LEN_B);
  assign sum_ok = (fifo_rdata == acc);

  assign drop_inc = fifo_ren && (state == HUNT) && (fifo_rdata != SOF_BYTE);
  assign ok_inc   = fifo_ren && (state == CHK) && sum_ok;
  assign err_inc  = fifo_ren && (((state == LEN) && !len_ok) || ((state == CHK) && !sum_ok));

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state      <= HUNT;
      acc        <= '0;
      remain     <= '0;
      stat_valid <= 1'b0;
      stat_ok    <= 1'b0;
    end else begin
      stat_valid <= 1'b0;
      stat_ok    <= 1'b0;
      case (state)
        HUNT: begin
          if (fifo_ren && (fifo_rdata == SOF_BYTE)) state <= LEN;
        end
        LEN: begin
          if (fifo_ren) begin
            if (len_ok) begin
              acc    <= fifo_rdata;
              remain <= fifo_rdata;
              state  <= PAYLOAD;
            end else begin
              stat_valid <= 1'b1;
              state      <= HUNT;
            end
          end
        end
        PAYLOAD: begin
          if (fifo_ren) begin
            acc    <= acc + fifo_rdata;
            remain <= remain - ONE_B;
            if (remain == ONE_B) state <= CHK;
          end
        end
        CHK: begin
          // Returning straight to HUNT lets the next SOF pop on the following cycle.
          if (fifo_ren) begin
            stat_valid <= 1'b1;
            stat_ok    <= sum_ok;
            state      <= HUNT;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  sat_counter u_ok_cnt (
    .clk (rclk),
    .rst (rrst),
    .inc (ok_inc),
    .cnt (ok_cnt)
  );

  sat_counter u_err_cnt (
    .clk (rclk),
    .rst (rrst),
    .inc (err_inc),
    .cnt (err_cnt)
  );

  sat_counter u_drop_cnt (
    .clk (rclk),
    .rst (rrst),
    .inc (drop_inc),
    .cnt (drop_cnt)
  );

endmodule

// File: tb/tb_frame_deframer.sv
// Directed bench: a queue models the show-ahead FIFO, expected payload bytes and
// status pulses are queued as frames are written and popped as the DUT emits them.
module tb_frame_deframer;

  logic        rclk;
  logic        rrst;
  logic        fifo_rempty;
  logic [7:0]  fifo_rdata;
  logic        fifo_ren;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic        stat_valid;
  logic        stat_ok;
  logic [15:0] ok_cnt;
  logic [15:0] err_cnt;
  logic [15:0] drop_cnt;

  frame_deframer dut (
    .rclk        (rclk),
    .rrst        (rrst),
    .fifo_rempty (fifo_rempty),
    .fifo_rdata  (fifo_rdata),
    .fifo_ren    (fifo_ren),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .stat_valid  (stat_valid),
    .stat_ok     (stat_ok),
    .ok_cnt      (ok_cnt),
    .err_cnt     (err_cnt),
    .drop_cnt    (drop_cnt)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  logic [7:0]  fq[$];
  logic [8:0]  exp_data[$];
  logic        exp_stat[$];
  logic [15:0] exp_ok;
  logic [15:0] exp_err;
  logic [15:0] exp_drop;
  int          checks;
  int          failures;
  int          cyc;
  logic        stall_mode;
  logic        prev_stall;
  logic [7:0]  prev_data;

  function automatic logic [15:0] sinc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic expd(input logic [7:0] d, input logic last);
    exp_data.push_back({last, d});
  endtask

  // One clock: drive FIFO/ready at negedge, check outputs mid-cycle, pop at posedge.
  task automatic step();
    logic       ren;
    logic [8:0] e;
    @(negedge rclk);
    cyc++;
    if (stall_mode) begin
      m_ready     = cyc[0];
      fifo_rempty = (fq.size() == 0) || (cyc % 3 == 0);
    end else begin
      m_ready     = 1'b1;
      fifo_rempty = (fq.size() == 0);
    end
    fifo_rdata = (fq.size() != 0) ? fq[0] : 8'h00;
    #2;
    chk("ren_when_empty", {31'd0, fifo_ren & fifo_rempty}, 0);
    if (exp_data.size() == 0) chk("spurious_valid", {31'd0, m_valid}, 0);
    if (prev_stall && m_valid) chk("stall_data", {24'd0, m_data}, {24'd0, prev_data});
    if (m_valid && m_ready && exp_data.size() != 0) begin
      e = exp_data.pop_front();
      chk("m_data", {24'd0, m_data}, {24'd0, e[7:0]});
      chk("m_last", {31'd0, m_last}, {31'd0, e[8]});
    end
    if (stat_valid) begin
      if (exp_stat.size() == 0) chk("spurious_stat", {31'd0, stat_valid}, 0);
      else chk("stat_ok", {31'd0, stat_ok}, {31'd0, exp_stat.pop_front()});
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    ren        = fifo_ren;
    @(posedge rclk);
    if (ren && !rrst && fq.size() != 0) void'(fq.pop_front());
  endtask

  task automatic run_idle(input string tag, input int limit);
    int n = 0;
    while ((fq.size() != 0 || exp_data.size() != 0 || exp_stat.size() != 0) && n < limit) begin
      step();
      n++;
    end
    chk({tag, "_idle"}, {31'd0, n < limit}, 1);
    step();
    step();
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_ok_cnt"},   {16'd0, ok_cnt},   {16'd0, exp_ok});
    chk({tag, "_err_cnt"},  {16'd0, err_cnt},  {16'd0, exp_err});
    chk({tag, "_drop_cnt"}, {16'd0, drop_cnt}, {16'd0, exp_drop});
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    stall_mode = 1'b0;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    exp_ok     = 16'd0;
    exp_err    = 16'd0;
    exp_drop   = 16'd0;

    // Reset state with data apparently present: no pop may be requested.
    rrst        = 1'b1;
    fifo_rempty = 1'b0;
    fifo_rdata  = 8'h5A;
    m_ready     = 1'b1;
    #3;
    chk("rst_fifo_ren",   {31'd0, fifo_ren}, 0);
    chk("rst_m_valid",    {31'd0, m_valid}, 0);
    chk("rst_m_last",     {31'd0, m_last}, 0);
    chk("rst_stat_valid", {31'd0, stat_valid}, 0);
    chk("rst_stat_ok",    {31'd0, stat_ok}, 0);
    chk_cnts("rst");
    step();
    step();
    #1 rrst = 1'b0;

    // Good frame.
    fq.push_back(8'hA5); fq.push_back(8'h03); fq.push_back(8'h11);
    fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h69);
    expd(8'h11, 1'b0); expd(8'h22, 1'b0); expd(8'h33, 1'b1);
    exp_stat.push_back(1'b1);
    exp_ok = sinc(exp_ok);
    run_idle("good", 50);
    chk_cnts("good");

    // Junk before SOF, then bad checksum.
    fq.push_back(8'h00); fq.push_back(8'h7F); fq.push_back(8'hA5);
    fq.push_back(8'h01); fq.push_back(8'h55); fq.push_back(8'h54);
    exp_drop = sinc(sinc(exp_drop));
    expd(8'h55, 1'b1);
    exp_stat.push_back(1'b0);
    exp_err = sinc(exp_err);
    run_idle("badsum", 50);
    chk_cnts("badsum");

    // Zero length and over-long length, both rejected without payload.
    fq.push_back(8'hA5); fq.push_back(8'h00);
    fq.push_back(8'hA5); fq.push_back(8'h41);
    exp_stat.push_back(1'b0);
    exp_stat.push_back(1'b0);
    exp_err = sinc(sinc(exp_err));
    run_idle("badlen", 50);
    chk_cnts("badlen");

    // Back-to-back frames: 9 bytes must drain in exactly 9 cycles.
    fq.push_back(8'hA5); fq.push_back(8'h01); fq.push_back(8'h10); fq.push_back(8'h11);
    fq.push_back(8'hA5); fq.push_back(8'h02); fq.push_back(8'h20); fq.push_back(8'h21);
    fq.push_back(8'h43);
    expd(8'h10, 1'b1); expd(8'h20, 1'b0); expd(8'h21, 1'b1);
    exp_stat.push_back(1'b1);
    exp_stat.push_back(1'b1);
    exp_ok = sinc(sinc(exp_ok));
    repeat (9) step();
    chk("b2b_drained", fq.size(), 0);
    run_idle("b2b", 20);
    chk_cnts("b2b");

    // SOF values as payload, with back-pressure and FIFO gaps.
    stall_mode = 1'b1;
    cyc        = 0;
    fq.push_back(8'hA5); fq.push_back(8'h02); fq.push_back(8'hA5);
    fq.push_back(8'hA5); fq.push_back(8'h4C);
    expd(8'hA5, 1'b0); expd(8'hA5, 1'b1);
    exp_stat.push_back(1'b1);
    exp_ok = sinc(exp_ok);
    run_idle("stall", 100);
    chk_cnts("stall");
    stall_mode = 1'b0;
    prev_stall = 1'b0;

    // Reset after two payload bytes of a length-4 frame.
    fq.push_back(8'hA5); fq.push_back(8'h04); fq.push_back(8'h01); fq.push_back(8'h02);
    expd(8'h01, 1'b0); expd(8'h02, 1'b0);
    run_idle("midframe", 50);
    fq.push_back(8'h03);
    fifo_rempty = 1'b0;
    fifo_rdata  = 8'h03;
    rrst        = 1'b1;
    #1;
    exp_ok   = 16'd0;
    exp_err  = 16'd0;
    exp_drop = 16'd0;
    chk("midrst_fifo_ren", {31'd0, fifo_ren}, 0);
    chk("midrst_m_valid",  {31'd0, m_valid}, 0);
    chk("midrst_m_last",   {31'd0, m_last}, 0);
    chk("midrst_stat",     {31'd0, stat_valid}, 0);
    chk_cnts("midrst");
    prev_stall = 1'b0;
    step();
    step();
    #1 rrst = 1'b0;
    exp_drop = sinc(exp_drop);
    fq.push_back(8'hA5); fq.push_back(8'h01); fq.push_back(8'h55); fq.push_back(8'h56);
    expd(8'h55, 1'b1);
    exp_stat.push_back(1'b1);
    exp_ok = sinc(exp_ok);
    run_idle("postrst", 50);
    chk_cnts("postrst");

    // Drop counter saturation.
    for (int i = 0; i < 65540; i++) begin
      fq.push_back(8'h00);
      exp_drop = sinc(exp_drop);
    end
    run_idle("sat", 70000);
    chk("sat_drop_cnt", {16'd0, drop_cnt}, 32'h0000FFFF);
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
    run_idle("sat2", 20);
    chk("sat_hold_drop_cnt", {16'd0, drop_cnt}, 32'h0000FFFF);
    chk_cnts("sat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
